// File: rtl/div_wb_buffer.sv
// Divider result holding buffer: circular FIFO in front of the writeback arbiter.
// Registered head copy, sticky overflow flag and occupancy high-water mark.
module div_wb_buffer #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_rd,
    input  logic [ID_WIDTH-1:0]          in_id,
    output logic                         wb_done,
    output logic [DATA_WIDTH-1:0]        wb_rd,
    output logic [ID_WIDTH-1:0]          wb_id,
    input  logic                         wb_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   high_water,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rd;
        logic [ID_WIDTH-1:0]   id;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_q;
    entry_t          head_nxt;
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_nxt;
    logic [PW-1:0]   rd_nxt;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   hw_q;
    logic [CW-1:0]   hw_nxt;
    logic            ovf_q;
    logic            enq;
    logic            deq;

    assign in_ready   = (cnt_q != FULL);
    assign wb_done    = (cnt_q != '0);
    assign enq        = in_valid & in_ready;
    assign deq        = wb_ack & wb_done;
    assign count      = cnt_q;
    assign high_water = hw_q;
    assign overflow   = ovf_q;
    assign wb_rd      = head_q.rd;
    assign wb_id      = head_q.id;

    always_comb begin
        wr_nxt  = wr_q;
        rd_nxt  = rd_q;
        cnt_nxt = cnt_q;
        if (enq) begin
            wr_nxt = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        end
        if (deq) begin
            rd_nxt = (rd_q == LAST) ? '0 : rd_q + 1'b1;
        end
        unique case ({enq, deq})
            2'b10:   cnt_nxt = cnt_q + 1'b1;
            2'b01:   cnt_nxt = cnt_q - 1'b1;
            default: cnt_nxt = cnt_q;
        endcase
        hw_nxt = (cnt_nxt > hw_q) ? cnt_nxt : hw_q;
    end

    // The new head is the incoming result only when it lands where the
    // read pointer is about to point (empty, or single entry being replaced).
    always_comb begin
        head_nxt = head_q;
        if (cnt_nxt != '0) begin
            if (enq && (wr_q == rd_nxt)) begin
                head_nxt.rd = in_rd;
                head_nxt.id = in_id;
            end else begin
                head_nxt = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_q] <= '{rd: in_rd, id: in_id};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            hw_q   <= '0;
            ovf_q  <= 1'b0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_nxt;
            rd_q   <= rd_nxt;
            cnt_q  <= cnt_nxt;
            hw_q   <= hw_nxt;
            head_q <= head_nxt;
            if (in_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule
